// File: rtl/fc_pkg.sv
// Shared constants, state encoding and beat payload for the FC layer sequencer.
package fc_pkg;

  localparam int unsigned FC_IN      = 48;
  localparam int unsigned FC_OUT     = 16;
  localparam int unsigned FC_W_TOTAL = FC_IN * FC_OUT + FC_OUT;
  localparam int unsigned FC_BEATS   = FC_IN / 3;
  localparam int unsigned FC_TIMEOUT = 64;

  localparam int unsigned FC_AW = 10;
  localparam int unsigned FC_DW = 16;
  localparam int unsigned FC_WW = 8;
  localparam int unsigned FC_CW = 8;
  localparam int unsigned FC_BW = $clog2(FC_BEATS);
  localparam int unsigned FC_TW = $clog2(FC_TIMEOUT);

  typedef enum logic [2:0] {
    W_LOAD   = 3'd0,
    W_WAIT   = 3'd1,
    READY    = 3'd2,
    PACK     = 3'd3,
    WAIT_OUT = 3'd4
  } fc_state_e;

  typedef struct packed {
    logic [FC_DW-1:0] d1;
    logic [FC_DW-1:0] d2;
    logic [FC_DW-1:0] d3;
  } fc_beat_t;

endpackage

// File: rtl/fc_layer_sequencer_packer.sv
// fc_triple_packer: steers accepted samples into three lanes and emits a
// one-cycle beat strobe once the third lane has been written.
module fc_triple_packer
  import fc_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             in_valid,
  input  logic [FC_DW-1:0] in_data,
  output logic             beat_c,
  output logic             beat_valid,
  output fc_beat_t         beat
);

  logic [1:0] lane_q, lane_d;
  fc_beat_t   beat_q, beat_d;
  logic       valid_q, valid_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q  <= 2'd0;
      beat_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      lane_q  <= lane_d;
      beat_q  <= beat_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    lane_d  = lane_q;
    beat_d  = beat_q;
    valid_d = 1'b0;
    beat_c  = 1'b0;
    if (clr) begin
      lane_d = 2'd0;
    end else if (en && in_valid) begin
      unique case (lane_q)
        2'd0:    beat_d.d1 = in_data;
        2'd1:    beat_d.d2 = in_data;
        default: beat_d.d3 = in_data;
      endcase
      // Third lane completes the beat; strobe lands the cycle after acceptance.
      if (lane_q == 2'd2) begin
        lane_d  = 2'd0;
        valid_d = 1'b1;
        beat_c  = 1'b1;
      end else begin
        lane_d = lane_q + 2'd1;
      end
    end
  end

  assign beat_valid = valid_q;
  assign beat       = beat_q;

endmodule

// File: rtl/fc_layer_sequencer.sv
// Sequencer for one FC layer engine: weight/bias fetch after reset, then
// per-frame activation packing, result wait and timeout supervision.
module fc_layer_sequencer
  import fc_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  output logic             w_rd_en,
  output logic [FC_AW-1:0] w_rd_addr,
  input  logic [FC_WW-1:0] w_rd_data,
  output logic             fc_weight_valid,
  output logic [FC_WW-1:0] fc_filter,
  input  logic             fc_weight_done,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [FC_DW-1:0] in_data,
  output logic             fc_i_valid,
  output logic [FC_DW-1:0] fc_data1,
  output logic [FC_DW-1:0] fc_data2,
  output logic [FC_DW-1:0] fc_data3,
  input  logic             fc_o_valid,
  output logic             busy,
  output logic             weights_ready,
  output logic             frame_done,
  output logic             timeout_err,
  output logic [FC_CW-1:0] frame_cnt
);

  localparam logic [FC_AW-1:0] W_LAST    = FC_AW'(FC_W_TOTAL - 1);
  localparam logic [FC_BW-1:0] BEAT_LAST = FC_BW'(FC_BEATS - 1);
  localparam logic [FC_TW-1:0] TO_LAST   = FC_TW'(FC_TIMEOUT - 1);

  fc_state_e        state_q, state_d;
  logic [FC_AW-1:0] waddr_q, waddr_d;
  logic             w_rd_en_q, w_rd_en_d;
  logic [FC_AW-1:0] w_rd_addr_q, w_rd_addr_d;
  logic             fc_weight_valid_q;
  logic [FC_BW-1:0] beat_cnt_q, beat_cnt_d;
  logic [FC_TW-1:0] timer_q, timer_d;
  logic             res_seen_q, res_seen_d;
  logic             weights_ready_q, weights_ready_d;
  logic             frame_done_q, frame_done_d;
  logic             timeout_err_q, timeout_err_d;
  logic [FC_CW-1:0] frame_cnt_q, frame_cnt_d;
  logic             busy_q, busy_d;
  logic             in_ready_q, in_ready_d;
  logic             pack_clr;
  logic             beat_c;
  fc_beat_t         beat;

  fc_triple_packer u_packer (
    .clk        (i_clk),
    .rst_n      (i_rst),
    .clr        (pack_clr),
    .en         (in_ready_q),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .beat_c     (beat_c),
    .beat_valid (fc_i_valid),
    .beat       (beat)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q           <= W_LOAD;
      waddr_q           <= '0;
      w_rd_en_q         <= 1'b0;
      w_rd_addr_q       <= '0;
      fc_weight_valid_q <= 1'b0;
      beat_cnt_q        <= '0;
      timer_q           <= '0;
      res_seen_q        <= 1'b0;
      weights_ready_q   <= 1'b0;
      frame_done_q      <= 1'b0;
      timeout_err_q     <= 1'b0;
      frame_cnt_q       <= '0;
      busy_q            <= 1'b0;
      in_ready_q        <= 1'b0;
    end else begin
      state_q           <= state_d;
      waddr_q           <= waddr_d;
      w_rd_en_q         <= w_rd_en_d;
      w_rd_addr_q       <= w_rd_addr_d;
      fc_weight_valid_q <= w_rd_en_q;
      beat_cnt_q        <= beat_cnt_d;
      timer_q           <= timer_d;
      res_seen_q        <= res_seen_d;
      weights_ready_q   <= weights_ready_d;
      frame_done_q      <= frame_done_d;
      timeout_err_q     <= timeout_err_d;
      frame_cnt_q       <= frame_cnt_d;
      busy_q            <= busy_d;
      in_ready_q        <= in_ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      W_LOAD:   if (waddr_q == W_LAST) state_d = W_WAIT;
      W_WAIT:   if (fc_weight_done) state_d = READY;
      READY:    if (i_start) state_d = PACK;
      PACK:     if (beat_c && (beat_cnt_q == BEAT_LAST)) state_d = WAIT_OUT;
      WAIT_OUT: if (res_seen_q || fc_o_valid || (timer_q == TO_LAST)) state_d = READY;
      default:  state_d = W_LOAD;
    endcase
  end

  always_comb begin
    waddr_d         = waddr_q;
    w_rd_en_d       = 1'b0;
    w_rd_addr_d     = w_rd_addr_q;
    beat_cnt_d      = beat_cnt_q;
    timer_d         = timer_q;
    res_seen_d      = res_seen_q;
    weights_ready_d = weights_ready_q;
    frame_done_d    = 1'b0;
    timeout_err_d   = 1'b0;
    frame_cnt_d     = frame_cnt_q;
    pack_clr        = 1'b0;
    unique case (state_q)
      W_LOAD: begin
        w_rd_en_d   = 1'b1;
        w_rd_addr_d = waddr_q;
        waddr_d     = waddr_q + FC_AW'(1);
      end
      W_WAIT: if (fc_weight_done) weights_ready_d = 1'b1;
      READY: begin
        if (i_start) begin
          pack_clr   = 1'b1;
          beat_cnt_d = '0;
          res_seen_d = 1'b0;
          timer_d    = '0;
        end
      end
      PACK: begin
        if (fc_o_valid) res_seen_d = 1'b1;
        if (beat_c) beat_cnt_d = beat_cnt_q + FC_BW'(1);
      end
      WAIT_OUT: begin
        timer_d = timer_q + FC_TW'(1);
        if (fc_o_valid) res_seen_d = 1'b1;
        // A result in the expiry cycle still counts as completion.
        if (res_seen_q || fc_o_valid) begin
          frame_done_d = 1'b1;
          frame_cnt_d  = frame_cnt_q + FC_CW'(1);
        end else if (timer_q == TO_LAST) begin
          timeout_err_d = 1'b1;
        end
      end
      default: ;
    endcase
    busy_d     = (state_d != READY);
    in_ready_d = (state_d == PACK);
  end

  assign w_rd_en         = w_rd_en_q;
  assign w_rd_addr       = w_rd_addr_q;
  assign fc_weight_valid = fc_weight_valid_q;
  assign fc_filter       = w_rd_data;
  assign in_ready        = in_ready_q;
  assign fc_data1        = beat.d1;
  assign fc_data2        = beat.d2;
  assign fc_data3        = beat.d3;
  assign busy            = busy_q;
  assign weights_ready   = weights_ready_q;
  assign frame_done      = frame_done_q;
  assign timeout_err     = timeout_err_q;
  assign frame_cnt       = frame_cnt_q;

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Self-checking bench for fc_layer_sequencer: ROM/engine models, a per-cycle
// compare process and directed frame scenarios.
module tb_fc_layer_sequencer;
  import fc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        i_start = 1'b0;
  logic        w_rd_en;
  logic [9:0]  w_rd_addr;
  logic [7:0]  w_rd_data;
  logic        fc_weight_valid;
  logic [7:0]  fc_filter;
  logic        fc_weight_done;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        fc_i_valid;
  logic [15:0] fc_data1, fc_data2, fc_data3;
  logic        fc_o_valid = 1'b0;
  logic        busy, weights_ready, frame_done, timeout_err;
  logic [7:0]  frame_cnt;

  fc_layer_sequencer dut (
    .i_clk(clk), .i_rst(rst_n), .i_start(i_start),
    .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data),
    .fc_weight_valid(fc_weight_valid), .fc_filter(fc_filter),
    .fc_weight_done(fc_weight_done),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .fc_i_valid(fc_i_valid), .fc_data1(fc_data1), .fc_data2(fc_data2),
    .fc_data3(fc_data3), .fc_o_valid(fc_o_valid),
    .busy(busy), .weights_ready(weights_ready), .frame_done(frame_done),
    .timeout_err(timeout_err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ROM returns the low address byte one cycle after the read strobe.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) w_rd_data <= '0;
    else if (w_rd_en) w_rd_data <= w_rd_addr[7:0];

  // Engine reports weight load done the cycle after its 784th byte.
  int eng_wcnt;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      eng_wcnt <= 0;
      fc_weight_done <= 1'b0;
    end else begin
      fc_weight_done <= 1'b0;
      if (fc_weight_valid) begin
        eng_wcnt <= eng_wcnt + 1;
        if (eng_wcnt == FC_W_TOTAL - 1) fc_weight_done <= 1'b1;
      end
    end

  // Samples handed to the DUT, in order; the compare process consumes them.
  logic [15:0] sent [0:255];
  int          sent_cnt = 0;

  int          rd_ptr = 0;
  int          widx, wrun, wrun_done = -1, first_addr = -1;
  bit          wprev, saw_en;
  int          total_beats = 0;
  int          beat_cycs [0:63];
  logic [47:0] beat_vals [0:63];
  int          done_cnt = 0, done_cyc = -1, to_cnt = 0, to_cyc = -1;
  int          exp_frames = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      widx = 0; wrun = 0; wprev = 0; saw_en = 0; exp_frames = 0;
    end else begin
      if (w_rd_en && !saw_en) begin
        saw_en = 1; first_addr = int'(w_rd_addr);
      end
      if (fc_weight_valid) begin
        chk("weight_byte", 64'(fc_filter), 64'(widx % 256));
        widx++; wrun++;
      end else if (wprev) begin
        wrun_done = wrun;
      end
      wprev = fc_weight_valid;
      if (fc_i_valid) begin
        chk("beat_complete", 64'(sent_cnt - rd_ptr >= 3), 64'(1));
        if (sent_cnt - rd_ptr >= 3) begin
          chk("beat_data", 64'({fc_data1, fc_data2, fc_data3}),
              64'({sent[rd_ptr], sent[rd_ptr+1], sent[rd_ptr+2]}));
          rd_ptr += 3;
        end
        if (total_beats < 64) begin
          beat_cycs[total_beats] = cyc;
          beat_vals[total_beats] = {fc_data1, fc_data2, fc_data3};
        end
        total_beats++;
      end
      if (frame_done) begin
        done_cnt++; done_cyc = cyc; exp_frames = (exp_frames + 1) % 256;
      end
      if (timeout_err) begin
        to_cnt++; to_cyc = cyc;
      end
      chk("frame_cnt", 64'(frame_cnt), 64'(exp_frames));
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_w_rd_en"}, 64'(w_rd_en), 0);
    chk({tag, "_w_rd_addr"}, 64'(w_rd_addr), 0);
    chk({tag, "_wvalid"}, 64'(fc_weight_valid), 0);
    chk({tag, "_filter"}, 64'(fc_filter), 0);
    chk({tag, "_in_ready"}, 64'(in_ready), 0);
    chk({tag, "_i_valid"}, 64'(fc_i_valid), 0);
    chk({tag, "_data"}, 64'({fc_data1, fc_data2, fc_data3}), 0);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_wready"}, 64'(weights_ready), 0);
    chk({tag, "_done"}, 64'(frame_done), 0);
    chk({tag, "_tout"}, 64'(timeout_err), 0);
    chk({tag, "_fcnt"}, 64'(frame_cnt), 0);
  endtask

  task automatic start_frame();
    i_start = 1'b1; tick(); i_start = 1'b0;
  endtask

  // Feeds 48 samples base+1..base+48; optional 50% gaps, early result
  // strobe after beat 15 and a stray i_start mid-frame.
  task automatic stream(input logic [15:0] base, input bit gappy, input bit early,
                        input bit stray_start, input int beat_base);
    int  k = 0;
    int  n = 0;
    bit  pulsed = 0;
    bit  acc;
    while (k < FC_IN && n < 1000) begin
      in_valid   = gappy ? (n % 2 == 0) : 1'b1;
      in_data    = base + 16'(k + 1);
      fc_o_valid = early && !pulsed && (total_beats - beat_base == 15);
      if (fc_o_valid) pulsed = 1;
      i_start    = stray_start && (k == 20);
      acc        = in_valid && in_ready;
      if (acc) begin
        sent[sent_cnt] = in_data;
        sent_cnt++;
      end
      tick();
      if (acc) k++;
      n++;
    end
    in_valid = 1'b0; fc_o_valid = 1'b0; i_start = 1'b0;
    chk("stream_accepted", 64'(k), 64'(FC_IN));
  endtask

  initial begin
    int n;
    int bb;
    #1 rst_n = 1'b0;
    #2 check_reset_outputs("rst0");
    tick(); tick(); tick();
    rst_n = 1'b1;

    // Partial load, stray start, then async reset at address 400.
    n = 0;
    while (w_rd_addr != 10'd400 && n < 1000) begin
      i_start = (n == 30);
      tick(); n++;
    end
    i_start = 1'b0;
    chk("reached_addr400", 64'(w_rd_addr), 64'd400);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst_mid");
    tick(); tick();
    rst_n = 1'b1;

    // Full load from address 0.
    n = 0;
    while (!weights_ready && n < 2000) begin
      i_start = (n == 50);
      tick(); n++;
    end
    i_start = 1'b0;
    tick(); tick(); tick();
    chk("wload_first_addr", 64'(first_addr), 64'd0);
    chk("wload_run_len", 64'(wrun_done), 64'd784);
    chk("wload_bytes", 64'(widx), 64'd784);
    chk("wload_ready", 64'(weights_ready), 64'd1);
    chk("wload_busy", 64'(busy), 64'd0);
    chk("wload_start_ignored", 64'(in_ready), 64'd0);

    // Frame 1: continuous 1..48, result two cycles after the last beat.
    bb = total_beats;
    start_frame();
    stream(16'd0, 0, 0, 0, bb);
    tick(); tick();
    fc_o_valid = 1'b1; tick(); fc_o_valid = 1'b0;
    tick(); tick();
    chk("f1_beats", 64'(total_beats - bb), 64'd16);
    chk("f1_first_beat", 64'(beat_vals[bb]), 64'({16'd1, 16'd2, 16'd3}));
    chk("f1_last_beat", 64'(beat_vals[bb+15]), 64'({16'd46, 16'd47, 16'd48}));
    for (int i = 1; i < 16; i++)
      chk("f1_beat_spacing", 64'(beat_cycs[bb+i] - beat_cycs[bb+i-1]), 64'd3);
    chk("f1_done_time", 64'(done_cyc - beat_cycs[bb+15]), 64'd3);
    chk("f1_frame_cnt", 64'(frame_cnt), 64'd1);
    chk("f1_busy", 64'(busy), 64'd0);

    // Frame 2: gappy stream, early result, stray mid-frame start.
    bb = total_beats;
    start_frame();
    stream(16'h8000, 1, 1, 1, bb);
    tick(); tick(); tick(); tick();
    chk("f2_beats", 64'(total_beats - bb), 64'd16);
    chk("f2_last_beat", 64'(beat_vals[bb+15]), 64'({16'h802E, 16'h802F, 16'h8030}));
    chk("f2_done_time", 64'(done_cyc - beat_cycs[bb+15]), 64'd1);
    chk("f2_frame_cnt", 64'(frame_cnt), 64'd2);
    chk("f2_done_cnt", 64'(done_cnt), 64'd2);
    chk("f2_no_requeue", 64'(in_ready), 64'd0);
    chk("f2_busy", 64'(busy), 64'd0);

    // Frame 3: no result, expect a timeout 64 cycles after the last beat.
    bb = total_beats;
    start_frame();
    stream(16'h7FF0, 0, 0, 0, bb);
    n = 0;
    while (to_cnt == 0 && n < 100) begin
      tick(); n++;
    end
    chk("f3_timeout_seen", 64'(to_cnt), 64'd1);
    chk("f3_timeout_time", 64'(to_cyc - beat_cycs[bb+15]), 64'd64);
    tick(); tick(); tick();
    chk("f3_timeout_pulse", 64'(to_cnt), 64'd1);
    chk("f3_beats", 64'(total_beats - bb), 64'd16);
    chk("f3_frame_cnt", 64'(frame_cnt), 64'd2);
    chk("f3_done_cnt", 64'(done_cnt), 64'd2);
    chk("f3_busy", 64'(busy), 64'd0);
    chk("f3_all_consumed", 64'(sent_cnt - rd_ptr), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
